// File: rtl/cnt_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnt_arb_pkg
// Description : Shared types and constants for the arbitrated up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic OP_INC = 1'b1;
    localparam logic OP_DEC = 1'b0;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 8;

endpackage : cnt_arb_pkg
`default_nettype wire

// File: rtl/cnt_rr_arb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cnt_rr_arb_ctrl_if
// Description : Requester-side bundle of the shared counter arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cnt_rr_arb_ctrl_if
    import cnt_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] op;
    logic             clr;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] rej;
    logic             busy;
    logic [CNT_W-1:0] cnt;

    modport master (
        output req, op, clr,
        input  gnt, rej, busy, cnt
    );

    modport slave (
        input  req, op, clr,
        output gnt, rej, busy, cnt
    );

endinterface : cnt_rr_arb_ctrl_if
`default_nettype wire

// File: rtl/cnt_ud_core.sv
`default_nettype none
// ============================================================================
// Module      : cnt_ud_core
// Description : Plain up/down counter register; clear wins over inc/dec.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_ud_core #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc,
    input  wire logic             dec,
    input  wire logic             clr,
    output logic      [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // No bound checks here: the controller never pulses past a bound.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule : cnt_ud_core
`default_nettype wire

// File: rtl/cnt_rr_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cnt_rr_arb_ctrl
// Description : Round-robin arbiter sequencing inc/dec requests into a shared
//               saturating-by-refusal counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_rr_arb_ctrl
    import cnt_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_VAL = 2**CNT_W - 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    cnt_rr_arb_ctrl_if.slave  bus
);

    localparam int               PTR_W     = $clog2(N_REQ);
    localparam logic [PTR_W-1:0] c_last    = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] c_max_val = CNT_W'(MAX_VAL);

    state_t           r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_win;
    logic             r_op;

    logic             w_any;
    logic [PTR_W-1:0] w_win;
    logic [N_REQ-1:0] w_gnt;
    logic [N_REQ-1:0] w_rej;
    logic             w_inc;
    logic             w_dec;
    logic [CNT_W-1:0] w_cnt;

    // First set request at or above r_ptr, wrapping modulo N_REQ.
    always_comb begin : p_pick
        int idx;
        w_any = 1'b0;
        w_win = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_any && bus.req[PTR_W'(idx)]) begin
                w_any = 1'b1;
                w_win = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_op    <= OP_DEC;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win   <= w_win;
                        r_op    <= bus.op[w_win];
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_ptr   <= (r_win == c_last) ? '0 : r_win + PTR_W'(1);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outcome decode must see clr in the ISSUE cycle itself, so it stays
    // combinational off the registered state and latched op.
    always_comb begin
        w_gnt = '0;
        w_rej = '0;
        w_inc = 1'b0;
        w_dec = 1'b0;
        if (r_state == ISSUE) begin
            if (bus.clr) begin
                w_rej[r_win] = 1'b1;
            end else if ((r_op == OP_INC) && (w_cnt == c_max_val)) begin
                w_rej[r_win] = 1'b1;
            end else if ((r_op == OP_DEC) && (w_cnt == '0)) begin
                w_rej[r_win] = 1'b1;
            end else begin
                w_gnt[r_win] = 1'b1;
                w_inc        = (r_op == OP_INC);
                w_dec        = (r_op == OP_DEC);
            end
        end
    end

    cnt_ud_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc),
        .dec   (w_dec),
        .clr   (bus.clr),
        .cnt   (w_cnt)
    );

    assign bus.gnt  = w_gnt;
    assign bus.rej  = w_rej;
    assign bus.busy = (r_state == ISSUE);
    assign bus.cnt  = w_cnt;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_gnt));
    a_rej_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_rej));
    a_gnt_rej_mx: assert property (@(posedge clk) disable iff (!rst_n) !(|w_gnt && |w_rej));
    a_inc_step:   assert property (@(posedge clk) disable iff (!rst_n)
                      (|w_gnt && r_op == OP_INC) |=> (w_cnt == $past(w_cnt) + CNT_W'(1)));
    a_dec_step:   assert property (@(posedge clk) disable iff (!rst_n)
                      (|w_gnt && r_op == OP_DEC) |=> (w_cnt == $past(w_cnt) - CNT_W'(1)));
    a_cnt_known:  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(w_cnt));
    a_busy_pulse: assert property (@(posedge clk) disable iff (!rst_n) bus.busy |=> !bus.busy);

endmodule : cnt_rr_arb_ctrl
`default_nettype wire

// File: tb/tb_cnt_rr_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_rr_arb_ctrl
// Description : Directed self-checking bench for the arbitrated counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_rr_arb_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    cnt_rr_arb_ctrl_if #(.N_REQ(4), .CNT_W(8)) bus ();

    cnt_rr_arb_ctrl #(
        .N_REQ   (4),
        .CNT_W   (8),
        .MAX_VAL (255)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n   = 1'b0;
        bus.req = '0;
        bus.op  = '0;
        bus.clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        bus.req = '0;
        bus.op  = '0;
        bus.clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.gnt, bus.rej, bus.busy, bus.cnt} !== 17'h0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b rej=%b busy=%b cnt=%0d exp all zero",
                     bus.gnt, bus.rej, bus.busy, bus.cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_inc;
        do_reset();
        bus.req = 4'b0001;
        bus.op  = 4'b0001;
        tick();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 || bus.rej !== 4'b0000) begin
            failures++;
            $display("FAIL single_gnt got gnt=%b rej=%b busy=%b exp gnt=0001 rej=0000 busy=1",
                     bus.gnt, bus.rej, bus.busy);
        end
        bus.req = '0;
        tick();
        checks++;
        if (bus.cnt !== 8'd1 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL single_cnt got cnt=%0d busy=%b gnt=%b exp cnt=1 busy=0 gnt=0000",
                     bus.cnt, bus.busy, bus.gnt);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_gnt [5];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        bus.req = 4'b1111;
        bus.op  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.gnt !== exp_gnt[i]) begin
                failures++;
                $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, bus.gnt, exp_gnt[i]);
            end
            tick();
            checks++;
            if (bus.cnt !== 8'(i + 1) || bus.gnt !== 4'b0000) begin
                failures++;
                $display("FAIL rr_cnt[%0d] got cnt=%0d gnt=%b exp cnt=%0d gnt=0000",
                         i, bus.cnt, bus.gnt, i + 1);
            end
        end
        bus.req = '0;
    endtask

    task automatic test_underflow;
        do_reset();
        bus.req = 4'b0100;
        bus.op  = 4'b0000;
        tick();
        checks++;
        if (bus.rej !== 4'b0100 || bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL uflow_rej got rej=%b gnt=%b exp rej=0100 gnt=0000", bus.rej, bus.gnt);
        end
        bus.req = 4'b1111;
        bus.op  = 4'b1111;
        tick();
        checks++;
        if (bus.cnt !== 8'd0) begin
            failures++;
            $display("FAIL uflow_cnt got=%0d exp=0", bus.cnt);
        end
        tick();
        checks++;
        if (bus.gnt !== 4'b1000) begin
            failures++;
            $display("FAIL uflow_next_winner got=%b exp=1000", bus.gnt);
        end
        bus.req = '0;
        tick();
        checks++;
        if (bus.cnt !== 8'd1) begin
            failures++;
            $display("FAIL uflow_after_cnt got=%0d exp=1", bus.cnt);
        end
    endtask

    task automatic test_overflow;
        do_reset();
        bus.req = 4'b0010;
        bus.op  = 4'b0010;
        repeat (255) begin
            tick();
            tick();
        end
        checks++;
        if (bus.cnt !== 8'd255) begin
            failures++;
            $display("FAIL oflow_fill got=%0d exp=255", bus.cnt);
        end
        tick();
        checks++;
        if (bus.rej !== 4'b0010 || bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL oflow_rej got rej=%b gnt=%b exp rej=0010 gnt=0000", bus.rej, bus.gnt);
        end
        bus.op = 4'b0000;
        tick();
        checks++;
        if (bus.cnt !== 8'd255) begin
            failures++;
            $display("FAIL oflow_hold got=%0d exp=255", bus.cnt);
        end
        tick();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL oflow_dec_gnt got=%b exp=0010", bus.gnt);
        end
        bus.req = '0;
        tick();
        checks++;
        if (bus.cnt !== 8'd254) begin
            failures++;
            $display("FAIL oflow_dec_cnt got=%0d exp=254", bus.cnt);
        end
    endtask

    task automatic test_clr;
        do_reset();
        bus.req = 4'b1000;
        bus.op  = 4'b1000;
        repeat (10) begin
            tick();
            tick();
        end
        checks++;
        if (bus.cnt !== 8'd10) begin
            failures++;
            $display("FAIL clr_setup got=%0d exp=10", bus.cnt);
        end
        tick();
        bus.clr = 1'b1;
        bus.req = '0;
        #1;
        checks++;
        if (bus.rej !== 4'b1000 || bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL clr_issue_rej got rej=%b gnt=%b exp rej=1000 gnt=0000", bus.rej, bus.gnt);
        end
        tick();
        bus.clr = 1'b0;
        checks++;
        if (bus.cnt !== 8'd0) begin
            failures++;
            $display("FAIL clr_issue_cnt got=%0d exp=0", bus.cnt);
        end
        // Bring cnt to 1, then clear in IDLE while a new inc is latched.
        bus.req = 4'b1000;
        tick();
        bus.req = '0;
        tick();
        bus.clr = 1'b1;
        bus.req = 4'b0100;
        bus.op  = 4'b0100;
        tick();
        bus.clr = 1'b0;
        bus.req = '0;
        #1;
        checks++;
        if (bus.gnt !== 4'b0100 || bus.cnt !== 8'd0) begin
            failures++;
            $display("FAIL clr_idle got gnt=%b cnt=%0d exp gnt=0100 cnt=0", bus.gnt, bus.cnt);
        end
        tick();
        checks++;
        if (bus.cnt !== 8'd1) begin
            failures++;
            $display("FAIL clr_idle_cnt got=%0d exp=1", bus.cnt);
        end
    endtask

    task automatic test_reset_mid_op;
        do_reset();
        bus.req = 4'b0100;
        bus.op  = 4'b0100;
        tick();
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL midrst_pre got busy=%b gnt=%b exp busy=1 gnt=0100", bus.busy, bus.gnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.rej !== 4'b0000 || bus.busy !== 1'b0 || bus.cnt !== 8'd0) begin
            failures++;
            $display("FAIL midrst_drop got gnt=%b rej=%b busy=%b cnt=%0d exp all zero",
                     bus.gnt, bus.rej, bus.busy, bus.cnt);
        end
        bus.req = 4'b0110;
        bus.op  = 4'b0110;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL midrst_first_winner got=%b exp=0010", bus.gnt);
        end
        bus.req = '0;
        tick();
        checks++;
        if (bus.cnt !== 8'd1) begin
            failures++;
            $display("FAIL midrst_cnt got=%0d exp=1", bus.cnt);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.op   = '0;
        bus.clr  = 1'b0;
        test_reset();
        test_single_inc();
        test_round_robin();
        test_underflow();
        test_overflow();
        test_clr();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cnt_rr_arb_ctrl
`default_nettype wire
